mesi_isc_mbus_arbiter: RTL



---
 rtl/mesi_isc_mbus_arbiter.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/mesi_isc_mbus_arbiter.sv
// rtl/mesi_isc_mbus_arbiter.sv - round-robin main-bus arbiter and snoop broadcast sequencer
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   mbus_cmd_i        four 3-bit CPU requests, CPU n at [3n+2:3n]
//   mbus_addr_i       four request addresses, CPU n at slice n
//   cbus_ack_i        per-CPU coherence acknowledge (level)
//   cbus_addr_o       latched address of the granted request
//   cbus_cmd_o        four 3-bit coherence commands, CPU n at [3n+2:3n]
//   mbus_ack_o        one-cycle completion pulse to the initiator
//   grant_id_o        granted CPU, valid while busy_o
//   busy_o            arbiter not in IDLE
//   error_o           sticky ack-collection timeout flag
module mesi_isc_mbus_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [11:0]             mbus_cmd_i,
    input  logic [4*ADDR_WIDTH-1:0] mbus_addr_i,
    input  logic [3:0]              cbus_ack_i,
    output logic [ADDR_WIDTH-1:0]   cbus_addr_o,
    output logic [11:0]             cbus_cmd_o,
    output logic [3:0]              mbus_ack_o,
    output logic [1:0]              grant_id_o,
    output logic                    busy_o,
    output logic                    error_o
);
    localparam logic [2:0] MB_WR       = 3'd1;
    localparam logic [2:0] MB_RD       = 3'd2;
    localparam logic [2:0] MB_WR_BROAD = 3'd3;
    localparam logic [2:0] MB_RD_BROAD = 3'd4;

    localparam logic [2:0] CB_WR_SNOOP = 3'd1;
    localparam logic [2:0] CB_RD_SNOOP = 3'd2;
    localparam logic [2:0] CB_EN_WR    = 3'd3;
    localparam logic [2:0] CB_EN_RD    = 3'd4;

    typedef enum logic [1:0] {ST_IDLE, ST_SNOOP, ST_ENABLE, ST_ACK} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              rr_ptr_q, rr_ptr_d;
    logic [1:0]              init_q, init_d;
    logic [2:0]              cmd_q, cmd_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [3:0]              mask_q, mask_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    just_acked_q, just_acked_d;
    logic [11:0]             cbus_cmd_q, cbus_cmd_d;
    logic [3:0]              mbus_ack_q, mbus_ack_d;
    logic                    busy_q, busy_d;
    logic                    error_q, error_d;

    // Arbitration scratch
    logic                    found;
    logic [1:0]              win_id;
    logic [2:0]              win_cmd;
    logic [1:0]              idx;
    logic [2:0]              req_cmd;
    logic [3:0]              init_oh;
    logic [7:0]              cnt_inc;
    logic [2:0]              snoop_val;

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        init_d       = init_q;
        cmd_d        = cmd_q;
        addr_d       = addr_q;
        mask_d       = mask_q;
        cnt_d        = cnt_q;
        just_acked_d = 1'b0;
        cbus_cmd_d   = '0;
        mbus_ack_d   = '0;
        error_d      = error_q;
        found        = 1'b0;
        win_id       = rr_ptr_q;
        win_cmd      = 3'd0;
        idx          = '0;
        req_cmd      = '0;
        init_oh      = 4'b0001 << init_q;
        cnt_inc      = cnt_q + 8'd1;
        snoop_val    = (cmd_q == MB_WR_BROAD) ? CB_WR_SNOOP : CB_RD_SNOOP;

        // Search from rr_ptr; the CPU acked last cycle is skipped so it can drop its command.
        for (int i = 0; i < 4; i++) begin
            idx     = rr_ptr_q + 2'(i);
            req_cmd = mbus_cmd_i[3*idx +: 3];
            if (!found && (req_cmd inside {[MB_WR:MB_RD_BROAD]})
                && !(just_acked_q && idx == init_q)) begin
                found   = 1'b1;
                win_id  = idx;
                win_cmd = req_cmd;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    init_d = win_id;
                    cmd_d  = win_cmd;
                    addr_d = mbus_addr_i[win_id*ADDR_WIDTH +: ADDR_WIDTH];
                    if (win_cmd == MB_WR || win_cmd == MB_RD) begin
                        state_d            = ST_ACK;
                        mbus_ack_d[win_id] = 1'b1;
                    end else begin
                        state_d = ST_SNOOP;
                        mask_d  = '0;
                        cnt_d   = '0;
                        for (int n = 0; n < 4; n++) begin
                            if (2'(n) != win_id)
                                cbus_cmd_d[3*n +: 3] = (win_cmd == MB_WR_BROAD) ? CB_WR_SNOOP
                                                                                 : CB_RD_SNOOP;
                        end
                    end
                end
            end
            ST_SNOOP: begin
                cnt_d  = cnt_inc;
                // Only slots still being snooped can contribute an ack.
                mask_d = mask_q | (cbus_ack_i & ~init_oh);
                if (&(mask_d | init_oh)) begin
                    state_d = ST_ENABLE;
                    cbus_cmd_d[3*init_q +: 3] = (cmd_q == MB_WR_BROAD) ? CB_EN_WR : CB_EN_RD;
                end else if (cnt_inc == 8'(TIMEOUT)) begin
                    state_d  = ST_IDLE;
                    error_d  = 1'b1;
                    rr_ptr_d = init_q + 2'd1;
                end else begin
                    for (int n = 0; n < 4; n++) begin
                        if (2'(n) != init_q && !mask_d[n])
                            cbus_cmd_d[3*n +: 3] = snoop_val;
                    end
                end
            end
            ST_ENABLE: begin
                cnt_d = cnt_inc;
                if (cbus_ack_i[init_q]) begin
                    state_d            = ST_ACK;
                    mbus_ack_d[init_q] = 1'b1;
                end else if (cnt_inc == 8'(TIMEOUT)) begin
                    state_d  = ST_IDLE;
                    error_d  = 1'b1;
                    rr_ptr_d = init_q + 2'd1;
                end else begin
                    cbus_cmd_d[3*init_q +: 3] = (cmd_q == MB_WR_BROAD) ? CB_EN_WR : CB_EN_RD;
                end
            end
            ST_ACK: begin
                state_d      = ST_IDLE;
                rr_ptr_d     = init_q + 2'd1;
                just_acked_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            init_q       <= '0;
            cmd_q        <= '0;
            addr_q       <= '0;
            mask_q       <= '0;
            cnt_q        <= '0;
            just_acked_q <= 1'b0;
            cbus_cmd_q   <= '0;
            mbus_ack_q   <= '0;
            busy_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            init_q       <= init_d;
            cmd_q        <= cmd_d;
            addr_q       <= addr_d;
            mask_q       <= mask_d;
            cnt_q        <= cnt_d;
            just_acked_q <= just_acked_d;
            cbus_cmd_q   <= cbus_cmd_d;
            mbus_ack_q   <= mbus_ack_d;
            busy_q       <= busy_d;
            error_q      <= error_d;
        end
    end

    assign cbus_addr_o = addr_q;
    assign cbus_cmd_o  = cbus_cmd_q;
    assign mbus_ack_o  = mbus_ack_q;
    assign grant_id_o  = init_q;
    assign busy_o      = busy_q;
    assign error_o     = error_q;
endmodule
